huc_bank_map: RTL and testbench



---
 rtl/huc_bank_map.sv | 99 +++++++++
 tb/tb_huc_bank_map.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/huc_bank_map.sv
// HuCard bank-switching mapper: card-space address -> ROM address via writable bank registers.
// Optional write lock (A5 to register F) enabled by defining HUC_BANK_MAP_LOCK_EN.
module huc_bank_map #(
  parameter int          WIN_LOG2 = 1,
  parameter int          ROM_AW   = 22,
  parameter logic [19:0] REG_BASE = 20'h01FF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              map_en,
  input  logic              mode,
  input  logic [19:0]       cpu_addr,
  input  logic [7:0]        cpu_dat,
  input  logic              cpu_ce_n,
  input  logic              cpu_we_n,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              bank_wr
);

  localparam int OFFW = 20 - WIN_LOG2;
  localparam int NWIN = 1 << WIN_LOG2;
  localparam int BW   = ROM_AW - OFFW;

  logic [BW-1:0]       bank [NWIN];
  logic                we_s1, we_s2, we_s3;
  logic                mode_q, map_en_q;
  logic [WIN_LOG2-1:0] win;
  logic [OFFW-1:0]     offset;
  logic [3:0]          k;
  logic                reload, wr_event, hit, hit_ok, upd_m0, upd_m1;
  logic [BW-1:0]       sel, m1_val;
  logic                unused_ok;

  assign win       = cpu_addr[19:OFFW];
  assign offset    = cpu_addr[OFFW-1:0];
  assign k         = cpu_addr[3:0];
  assign unused_ok = ^cpu_dat;

  // Reload has priority over any write landing in the same cycle.
  always_comb begin
    reload   = (mode != mode_q) | (map_en & ~map_en_q);
    wr_event = we_s3 & ~we_s2;
    hit      = wr_event & ~cpu_ce_n & map_en & ~reload
               & (cpu_addr[19:4] == REG_BASE[19:4]);
  end

`ifdef HUC_BANK_MAP_LOCK_EN
  logic locked, lock_wr;

  assign lock_wr = hit & ~locked & (k == 4'hF) & (cpu_dat == 8'hA5);
  assign hit_ok  = hit & ~locked & ~lock_wr;

  // Lock survives mode changes and map_en toggles; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          locked <= 1'b0;
    else if (lock_wr) locked <= 1'b1;
  end
`else
  assign hit_ok = hit;
`endif

  always_comb begin
    upd_m0 = hit_ok & ~mode & (k != 4'h0) & (32'(k) < NWIN);
    upd_m1 = hit_ok & mode;
    m1_val = BW'(NWIN - 1) + BW'(k);
    sel    = '0;
    if (!map_en)        sel = BW'(win);
    else if (win != '0) sel = bank[win];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_s1    <= 1'b1;
      we_s2    <= 1'b1;
      we_s3    <= 1'b1;
      mode_q   <= 1'b0;
      map_en_q <= 1'b0;
      rom_addr <= '0;
      bank_wr  <= 1'b0;
      for (int w = 0; w < NWIN; w++) bank[w] <= BW'(w);
    end else begin
      we_s1    <= cpu_we_n;
      we_s2    <= we_s1;
      we_s3    <= we_s2;
      mode_q   <= mode;
      map_en_q <= map_en;
      rom_addr <= {sel, offset};
      bank_wr  <= upd_m0 | upd_m1;
      if (reload) begin
        for (int w = 0; w < NWIN; w++) bank[w] <= BW'(w);
      end else if (upd_m0) begin
        bank[k[WIN_LOG2-1:0]] <= cpu_dat[BW-1:0];
      end else if (upd_m1) begin
        bank[NWIN-1] <= m1_val;
      end
    end
  end

endmodule

// File: tb/tb_huc_bank_map.sv
// Directed bench for huc_bank_map at WIN_LOG2=1, ROM_AW=22 (3-bit bank field, 19-bit offset).
module tb_huc_bank_map;

  logic        clk = 1'b0;
  logic        rst;
  logic        map_en;
  logic        mode;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        cpu_ce_n;
  logic        cpu_we_n;
  logic [21:0] rom_addr;
  logic        bank_wr;

  int checks   = 0;
  int failures = 0;

  huc_bank_map #(.WIN_LOG2(1), .ROM_AW(22), .REG_BASE(20'h01FF0)) dut (
    .clk(clk), .rst(rst), .map_en(map_en), .mode(mode),
    .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .cpu_ce_n(cpu_ce_n),
    .cpu_we_n(cpu_we_n), .rom_addr(rom_addr), .bank_wr(bank_wr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write cycle: strobe low 6 clocks, then 3 idle clocks; counts bank_wr pulses.
  task automatic do_write(input logic [19:0] a, input logic [7:0] d,
                          input logic ce_n, output int pulses);
    pulses   = 0;
    cpu_addr = a;
    cpu_dat  = d;
    cpu_ce_n = ce_n;
    cpu_we_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bank_wr === 1'b1) pulses++;
    end
    cpu_we_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bank_wr === 1'b1) pulses++;
    end
    cpu_ce_n = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; map_en = 1'b1; mode = 1'b0; cpu_addr = 20'h80123;
    cpu_dat = 8'h00; cpu_ce_n = 1'b1; cpu_we_n = 1'b1;
    tick(); tick();
    checks++;
    if (rom_addr !== 22'h0) begin
      failures++; $display("FAIL reset_rom_addr got=%h exp=%h", rom_addr, 22'h0);
    end
    checks++;
    if (bank_wr !== 1'b0) begin
      failures++; $display("FAIL reset_bank_wr got=%b exp=0", bank_wr);
    end
    rst = 1'b0;
    tick(); tick();
  endtask

  task automatic test_identity();
    cpu_addr = 20'h80123; tick();
    checks++;
    if (rom_addr !== 22'h080123) begin
      failures++; $display("FAIL ident_win1 got=%h exp=%h", rom_addr, 22'h080123);
    end
    cpu_addr = 20'h00456; tick();
    checks++;
    if (rom_addr !== 22'h000456) begin
      failures++; $display("FAIL ident_win0 got=%h exp=%h", rom_addr, 22'h000456);
    end
  endtask

  task automatic test_mode0_write();
    int p;
    do_write(20'h01FF1, 8'h05, 1'b0, p);
    checks++;
    if (p !== 1) begin
      failures++; $display("FAIL m0_wr_pulses got=%0d exp=1", p);
    end
    cpu_addr = 20'h80010; tick();
    checks++;
    if (rom_addr !== 22'h280010) begin
      failures++; $display("FAIL m0_bank5 got=%h exp=%h", rom_addr, 22'h280010);
    end
    do_write(20'h01FF0, 8'h03, 1'b0, p);
    cpu_addr = 20'h80010; tick();
    checks++;
    if (p !== 0 || rom_addr !== 22'h280010) begin
      failures++; $display("FAIL m0_k0_ignored pulses=%0d got=%h exp=0/%h", p, rom_addr, 22'h280010);
    end
    do_write(20'h01FE1, 8'h03, 1'b0, p);
    cpu_addr = 20'h80010; tick();
    checks++;
    if (p !== 0 || rom_addr !== 22'h280010) begin
      failures++; $display("FAIL m0_outside_ignored pulses=%0d got=%h exp=0/%h", p, rom_addr, 22'h280010);
    end
    do_write(20'h01FF1, 8'hFE, 1'b0, p);
    cpu_addr = 20'h80000; tick();
    checks++;
    if (p !== 1 || rom_addr !== 22'h300000) begin
      failures++; $display("FAIL m0_trunc pulses=%0d got=%h exp=1/%h", p, rom_addr, 22'h300000);
    end
  endtask

  task automatic test_mode1_write();
    int p;
    mode = 1'b1; tick(); tick();
    cpu_addr = 20'h80000; tick();
    checks++;
    if (rom_addr !== 22'h080000) begin
      failures++; $display("FAIL m1_mode_reload got=%h exp=%h", rom_addr, 22'h080000);
    end
    do_write(20'h01FF3, 8'h00, 1'b0, p);
    cpu_addr = 20'hFFFFF; tick();
    checks++;
    if (p !== 1 || rom_addr !== 22'h27FFFF) begin
      failures++; $display("FAIL m1_k3 pulses=%0d got=%h exp=1/%h", p, rom_addr, 22'h27FFFF);
    end
    do_write(20'h01FF1, 8'h00, 1'b1, p);
    cpu_addr = 20'hFFFFF; tick();
    checks++;
    if (p !== 0 || rom_addr !== 22'h27FFFF) begin
      failures++; $display("FAIL m1_ce_high pulses=%0d got=%h exp=0/%h", p, rom_addr, 22'h27FFFF);
    end
    do_write(20'h01FFF, 8'h00, 1'b0, p);
    cpu_addr = 20'h80005; tick();
    checks++;
    if (p !== 1 || rom_addr !== 22'h000005) begin
      failures++; $display("FAIL m1_kF_wrap pulses=%0d got=%h exp=1/%h", p, rom_addr, 22'h000005);
    end
  endtask

  // Mode flips exactly in the cycle the write event is live; reload must win.
  task automatic test_reload_race();
    int p = 0;
    cpu_addr = 20'h01FF1; cpu_dat = 8'h05; cpu_ce_n = 1'b0; cpu_we_n = 1'b0;
    tick(); tick();
    mode = ~mode;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bank_wr === 1'b1) p++;
    end
    cpu_we_n = 1'b1; cpu_ce_n = 1'b1;
    tick(); tick(); tick();
    cpu_addr = 20'h80000; tick();
    checks++;
    if (p !== 0) begin
      failures++; $display("FAIL race_no_pulse got=%0d exp=0", p);
    end
    checks++;
    if (rom_addr !== 22'h080000) begin
      failures++; $display("FAIL race_reload got=%h exp=%h", rom_addr, 22'h080000);
    end
  endtask

  task automatic test_map_en();
    int p;
    mode = 1'b0; tick(); tick();
    do_write(20'h01FF1, 8'h05, 1'b0, p);
    map_en = 1'b0;
    cpu_addr = 20'h80010; tick();
    checks++;
    if (rom_addr !== 22'h080010) begin
      failures++; $display("FAIL flat_addr got=%h exp=%h", rom_addr, 22'h080010);
    end
    do_write(20'h01FF1, 8'h07, 1'b0, p);
    checks++;
    if (p !== 0) begin
      failures++; $display("FAIL flat_wr_ignored got=%0d exp=0", p);
    end
    map_en = 1'b1; tick(); tick();
    cpu_addr = 20'h80010; tick();
    checks++;
    if (rom_addr !== 22'h080010) begin
      failures++; $display("FAIL en_rise_reload got=%h exp=%h", rom_addr, 22'h080010);
    end
  endtask

  task automatic test_back_to_back();
    int p1, p2;
    do_write(20'h01FF1, 8'h02, 1'b0, p1);
    do_write(20'h01FF1, 8'h07, 1'b0, p2);
    cpu_addr = 20'h80000; tick();
    checks++;
    if (p1 !== 1 || p2 !== 1 || rom_addr !== 22'h380000) begin
      failures++; $display("FAIL b2b pulses=%0d/%0d got=%h exp=1/1/%h", p1, p2, rom_addr, 22'h380000);
    end
  endtask

  task automatic test_reset_mid_write();
    int p = 0;
    cpu_addr = 20'h01FF1; cpu_dat = 8'h06; cpu_ce_n = 1'b0; cpu_we_n = 1'b0;
    tick();
    #2 rst = 1'b1; cpu_we_n = 1'b1;
    #1;
    checks++;
    if (rom_addr !== 22'h0 || bank_wr !== 1'b0) begin
      failures++; $display("FAIL rst_async got=%h/%b exp=0/0", rom_addr, bank_wr);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bank_wr === 1'b1) p++;
    end
    cpu_ce_n = 1'b1;
    cpu_addr = 20'h80000; tick();
    checks++;
    if (p !== 0 || rom_addr !== 22'h080000) begin
      failures++; $display("FAIL rst_discard pulses=%0d got=%h exp=0/%h", p, rom_addr, 22'h080000);
    end
  endtask

  task automatic test_lock();
    int p1, p2, p3;
    do_write(20'h01FFF, 8'hA5, 1'b0, p1);
    do_write(20'h01FF1, 8'h03, 1'b0, p2);
    cpu_addr = 20'h80000; tick();
`ifdef HUC_BANK_MAP_LOCK_EN
    checks++;
    if (p1 !== 0 || p2 !== 0 || rom_addr !== 22'h080000) begin
      failures++; $display("FAIL lock_blocks pulses=%0d/%0d got=%h exp=0/0/%h", p1, p2, rom_addr, 22'h080000);
    end
    rst = 1'b1; tick(); rst = 1'b0; tick(); tick();
    do_write(20'h01FF1, 8'h03, 1'b0, p3);
    cpu_addr = 20'h80000; tick();
    checks++;
    if (p3 !== 1 || rom_addr !== 22'h180000) begin
      failures++; $display("FAIL lock_cleared pulses=%0d got=%h exp=1/%h", p3, rom_addr, 22'h180000);
    end
`else
    checks++;
    if (p1 !== 0 || p2 !== 1 || rom_addr !== 22'h180000) begin
      failures++; $display("FAIL nolock_kF pulses=%0d/%0d got=%h exp=0/1/%h", p1, p2, rom_addr, 22'h180000);
    end
    do_write(20'h01FF1, 8'h04, 1'b0, p3);
    cpu_addr = 20'h80000; tick();
    checks++;
    if (p3 !== 1 || rom_addr !== 22'h200000) begin
      failures++; $display("FAIL nolock_next pulses=%0d got=%h exp=1/%h", p3, rom_addr, 22'h200000);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_identity();
    test_mode0_write();
    test_mode1_write();
    test_reload_race();
    test_map_en();
    test_back_to_back();
    test_reset_mid_write();
    test_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
